// File: rtl/audio_mixer_tdm.sv
// rtl/audio_mixer_tdm.sv - N-channel stereo mixer, time-multiplexed MAC per side, saturation, sigma-delta DACs
module audio_mixer_tdm #(
    parameter int NCH = 8,
    parameter int SW  = 8,
    parameter int OW  = 10,
    parameter int CW  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*SW-1:0] ch_in,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [5:0]        cfg_wdata,
    output logic [5:0]        cfg_rdata,
    output logic [OW-1:0]     left,
    output logic [OW-1:0]     right,
    output logic              sample_valid,
    output logic              clip_l,
    output logic              clip_r,
    output logic              dac_l,
    output logic              dac_r
);
    localparam int IW = $clog2(NCH);
    localparam int PW = $clog2(NCH + 1);
    localparam int AW = SW + IW + 1;
    localparam int XW = ((AW > OW) ? AW : OW) + 1;
    localparam logic [XW-1:0] MAXOUT = XW'(2 ** OW - 1);
    localparam logic [CW:0]   NCH_C  = (CW + 1)'(NCH);
    localparam logic [PW-1:0] PH_END = PW'(NCH);

    logic [5:0]    cfg_live [NCH];
    logic [5:0]    cfg_shd  [NCH];
    logic [SW-1:0] snap     [NCH];
    logic [PW-1:0] ph;
    logic          first;
    logic [AW-1:0] acc_l, acc_r;
    logic [OW:0]   sd_l, sd_r;

    logic          cfg_hit;
    logic [IW-1:0] cfg_idx;
    logic [IW-1:0] c_idx;
    logic [4:0]    vol_p1;
    logic [SW+3:0] prod;
    logic [SW-1:0] term;
    logic [XW-1:0] acc_lx, acc_rx;
    logic          sat_l, sat_r;
    logic [OW-1:0] mix_l, mix_r;

    always_comb begin
        cfg_hit   = {1'b0, cfg_ch} < NCH_C;
        cfg_idx   = IW'(cfg_ch);
        cfg_rdata = cfg_hit ? cfg_live[cfg_idx] : 6'd0;
    end

    // vol+1 in 1..16 makes vol=15 a unity gain after the >>4
    always_comb begin
        c_idx  = IW'(ph - PW'(1));
        vol_p1 = {1'b0, cfg_shd[c_idx][3:0]} + 5'd1;
        prod   = {4'b0, snap[c_idx]} * {{(SW - 1){1'b0}}, vol_p1};
        term   = SW'(prod >> 4);
    end

    always_comb begin
        acc_lx = XW'(acc_l);
        acc_rx = XW'(acc_r);
        sat_l  = acc_lx > MAXOUT;
        sat_r  = acc_rx > MAXOUT;
        mix_l  = sat_l ? {OW{1'b1}} : OW'(acc_lx);
        mix_r  = sat_r ? {OW{1'b1}} : OW'(acc_rx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                cfg_live[k] <= 6'h3f;
                cfg_shd[k]  <= 6'h3f;
                snap[k]     <= '0;
            end
            ph           <= '0;
            first        <= 1'b1;
            acc_l        <= '0;
            acc_r        <= '0;
            left         <= '0;
            right        <= '0;
            sample_valid <= 1'b0;
            clip_l       <= 1'b0;
            clip_r       <= 1'b0;
        end else begin
            if (cfg_we && cfg_hit)
                cfg_live[cfg_idx] <= cfg_wdata;
            ph <= (ph == PH_END) ? '0 : ph + PW'(1);
            sample_valid <= 1'b0;
            clip_l       <= 1'b0;
            clip_r       <= 1'b0;
            if (ph == '0) begin
                // snapshot sees the live config from before this edge's write
                for (int k = 0; k < NCH; k++) begin
                    snap[k]    <= ch_in[k*SW +: SW];
                    cfg_shd[k] <= cfg_live[k];
                end
                acc_l        <= '0;
                acc_r        <= '0;
                left         <= mix_l;
                right        <= mix_r;
                sample_valid <= !first;
                clip_l       <= !first && sat_l;
                clip_r       <= !first && sat_r;
                first        <= 1'b0;
            end else begin
                if (cfg_shd[c_idx][5])
                    acc_l <= acc_l + AW'(term);
                if (cfg_shd[c_idx][4])
                    acc_r <= acc_r + AW'(term);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sd_l  <= '0;
            sd_r  <= '0;
            dac_l <= 1'b0;
            dac_r <= 1'b0;
        end else begin
            sd_l  <= {1'b0, sd_l[OW-1:0]} + {1'b0, left};
            sd_r  <= {1'b0, sd_r[OW-1:0]} + {1'b0, right};
            dac_l <= sd_l[OW];
            dac_r <= sd_r[OW];
        end
    end
endmodule
